// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-through data cache.
// Holds memcnf encodings, FSM state type, byte-mask and load-extract functions.
package dcache_pkg;

  localparam logic [1:0] MEMCNF_NONE = 2'b00;
  localparam logic [1:0] MEMCNF_BYTE = 2'b01;
  localparam logic [1:0] MEMCNF_HALF = 2'b10;
  localparam logic [1:0] MEMCNF_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RFILL,
    ST_WTHRU,
    ST_BYP
  } state_t;

  function automatic logic [3:0] byte_mask(
    input logic [1:0] cnf,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b0000;
    case (cnf)
      MEMCNF_BYTE: m = 4'b0001 << off;
      MEMCNF_HALF: m = 4'b0011 << off;
      MEMCNF_WORD: m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(
    input logic [31:0] line,
    input logic [1:0]  cnf,
    input logic [1:0]  off
  );
    logic [31:0] s;
    logic [31:0] r;
    s = line >> {off, 3'b000};
    case (cnf)
      MEMCNF_BYTE: r = {24'h0, s[7:0]};
      MEMCNF_HALF: r = {16'h0, s[15:0]};
      default:     r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/data/valid arrays of the direct-mapped cache, one word per line.
// Ports: comb read (i_rd_idx -> o_rd_*), masked write (i_we..i_wr_alloc), i_clr clears valids.
module dcache_line_store #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_W      = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [31:0]           o_rd_data,
  output logic [3:0]            o_rd_valid,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]      i_wr_tag,
  input  logic [31:0]           i_wr_data,
  input  logic [3:0]            i_wr_mask,
  input  logic                  i_wr_alloc
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [TAG_W-1:0] r_tag   [LINES];
  logic [31:0]      r_data  [LINES];
  logic [3:0]       r_valid [LINES];

  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];
  assign o_rd_valid = r_valid[i_rd_idx];

  // Allocation replaces the valid set; otherwise new bytes merge in.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      for (int i = 0; i < LINES; i++)
        r_valid[i] <= 4'b0000;
    end else if (i_we) begin
      if (i_wr_alloc)
        r_valid[i_wr_idx] <= i_wr_mask;
      else
        r_valid[i_wr_idx] <= r_valid[i_wr_idx] | i_wr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_wr_alloc)
        r_tag[i_wr_idx] <= i_wr_tag;
      for (int b = 0; b < 4; b++)
        if (i_wr_mask[b])
          r_data[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through data cache between MEM stage and mem-control.
// Ports: MEM side (req_i..flush_i, data_o, data_available_o); memory side (data_needed..addr_needed).
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int              ADDR_WIDTH   = 32,
  parameter int              INDEX_BITS   = 7,
  parameter logic [31:0]     IO_BASE      = 32'h30000,
  parameter int              IO_SIZE_LOG2 = 3,
  parameter int              CACHE_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_i,
  input  logic [1:0]            memcnf_i,
  input  logic [31:0]           data_write_i,
  input  logic                  flush_i,
  output logic [31:0]           data_o,
  output logic                  data_available_o,
  output logic                  data_needed,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  wr_o,
  output logic [1:0]            memcnf_o,
  output logic [31:0]           data_write_o,
  input  logic                  data_available_i,
  input  logic [31:0]           data_i,
  input  logic                  addr_needed
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
  localparam logic [ADDR_WIDTH-1:0] LP_IO_BASE =
    ADDR_WIDTH'(IO_BASE);
  localparam logic [ADDR_WIDTH-1:0] LP_IO_SZ =
    ADDR_WIDTH'(1) << IO_SIZE_LOG2;

  state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr;
  logic [1:0]            r_memcnf;
  logic [31:0]           r_wdata;
  logic                  r_flush_pend;
  logic [31:0]           r_data_o;
  logic                  r_dav;

  logic [1:0]            w_off_i;
  logic [INDEX_BITS-1:0] w_idx_i, w_idx_r, w_rd_idx;
  logic [TAG_W-1:0]      w_tag_i, w_tag_r;
  logic [3:0]            w_mask_i;
  logic [ADDR_WIDTH-1:0] w_io_off;
  logic                  w_io, w_misal, w_byp;
  logic                  w_flush, w_accept, w_ld_hit;
  logic [TAG_W-1:0]      w_rd_tag;
  logic [31:0]           w_rd_data;
  logic [3:0]            w_rd_valid;
  logic                  w_wr_tag_hit;

  logic                  w_clr, w_we, w_alloc;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_mask;
  logic                  w_fill, w_byp_ld, w_done;

  assign w_off_i = addr_i[1:0];
  assign w_idx_i = addr_i[INDEX_BITS+1:2];
  assign w_tag_i = addr_i[ADDR_WIDTH-1:INDEX_BITS+2];
  assign w_idx_r = r_addr[INDEX_BITS+1:2];
  assign w_tag_r = r_addr[ADDR_WIDTH-1:INDEX_BITS+2];

  assign w_mask_i = byte_mask(memcnf_i, w_off_i);

  assign w_io_off = addr_i - LP_IO_BASE;
  assign w_io     = (addr_i >= LP_IO_BASE) &&
                    (w_io_off < LP_IO_SZ);
  assign w_misal  = ((memcnf_i == MEMCNF_HALF) && w_off_i[0]) ||
                    ((memcnf_i == MEMCNF_WORD) && (w_off_i != 2'b00));
  assign w_byp    = (CACHE_EN == 0) || w_io || w_misal;

  assign w_flush  = flush_i || r_flush_pend;
  assign w_accept = (r_state == ST_IDLE) && req_i &&
                    (memcnf_i != MEMCNF_NONE) &&
                    !r_dav && !w_flush;

  // IDLE looks up the incoming request; WTHRU looks up its own line.
  assign w_rd_idx = (r_state == ST_IDLE) ? w_idx_i : w_idx_r;

  assign w_ld_hit = w_accept && !w_byp && !wr_i &&
                    (w_rd_tag == w_tag_i) &&
                    ((w_rd_valid & w_mask_i) == w_mask_i);

  assign w_wr_tag_hit = (w_rd_tag == w_tag_r) && (|w_rd_valid);

  dcache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_rd_idx   (w_rd_idx),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .o_rd_valid (w_rd_valid),
    .i_we       (w_we),
    .i_wr_idx   (w_idx_r),
    .i_wr_tag   (w_tag_r),
    .i_wr_data  (w_wr_data),
    .i_wr_mask  (w_wr_mask),
    .i_wr_alloc (w_alloc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    data_needed  = 1'b0;
    addr_o       = '0;
    wr_o         = 1'b0;
    memcnf_o     = MEMCNF_NONE;
    data_write_o = '0;
    w_clr        = 1'b0;
    w_we         = 1'b0;
    w_alloc      = 1'b0;
    w_wr_data    = '0;
    w_wr_mask    = 4'b0000;
    w_fill       = 1'b0;
    w_byp_ld     = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_flush) begin
          w_clr = 1'b1;
        end else if (w_accept) begin
          if (w_byp)        w_next = ST_BYP;
          else if (wr_i)    w_next = ST_WTHRU;
          else if (!w_ld_hit) w_next = ST_RFILL;
        end
      end
      ST_RFILL: begin
        data_needed = 1'b1;
        addr_o      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        memcnf_o    = MEMCNF_WORD;
        if (data_available_i) begin
          w_we      = 1'b1;
          w_alloc   = 1'b1;
          w_wr_mask = 4'b1111;
          w_wr_data = data_i;
          w_fill    = 1'b1;
          w_done    = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_WTHRU: begin
        data_needed  = 1'b1;
        wr_o         = 1'b1;
        addr_o       = r_addr;
        memcnf_o     = r_memcnf;
        data_write_o = r_wdata;
        if (addr_needed) begin
          w_we      = 1'b1;
          w_alloc   = !w_wr_tag_hit;
          w_wr_mask = byte_mask(r_memcnf, r_addr[1:0]);
          w_wr_data = r_wdata << {r_addr[1:0], 3'b000};
          w_done    = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_BYP: begin
        data_needed  = 1'b1;
        wr_o         = r_wr;
        addr_o       = r_addr;
        memcnf_o     = r_memcnf;
        data_write_o = r_wdata;
        if (!r_wr && data_available_i) begin
          w_byp_ld = 1'b1;
          w_done   = 1'b1;
          w_next   = ST_IDLE;
        end else if (r_wr && addr_needed) begin
          w_done   = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_memcnf     <= MEMCNF_NONE;
      r_wdata      <= '0;
      r_flush_pend <= 1'b0;
      r_data_o     <= '0;
      r_dav        <= 1'b0;
    end else begin
      r_dav <= w_done || w_ld_hit;
      if (w_accept) begin
        r_addr   <= addr_i;
        r_wr     <= wr_i;
        r_memcnf <= memcnf_i;
        r_wdata  <= data_write_i;
      end
      if (w_ld_hit)
        r_data_o <= load_extract(w_rd_data, memcnf_i, w_off_i);
      if (w_fill)
        r_data_o <= load_extract(data_i, r_memcnf, r_addr[1:0]);
      if (w_byp_ld)
        r_data_o <= data_i;
      // A flush seen while busy waits for the next IDLE cycle.
      if (r_state == ST_IDLE)
        r_flush_pend <= 1'b0;
      else if (flush_i)
        r_flush_pend <= 1'b1;
    end
  end

  assign data_o           = r_data_o;
  assign data_available_o = r_dav;

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt against a byte-granular cache model.
// Bench acts as mem-control with random response delays.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [31:0] addr_i;
  logic        wr_i;
  logic [1:0]  memcnf_i;
  logic [31:0] data_write_i;
  logic        flush_i;
  logic [31:0] data_o;
  logic        data_available_o;
  logic        data_needed;
  logic [31:0] addr_o;
  logic        wr_o;
  logic [1:0]  memcnf_o;
  logic [31:0] data_write_o;
  logic        data_available_i;
  logic [31:0] data_i;
  logic        addr_needed;

  dcache_wt dut (
    .clk              (clk),
    .rst              (rst),
    .req_i            (req_i),
    .addr_i           (addr_i),
    .wr_i             (wr_i),
    .memcnf_i         (memcnf_i),
    .data_write_i     (data_write_i),
    .flush_i          (flush_i),
    .data_o           (data_o),
    .data_available_o (data_available_o),
    .data_needed      (data_needed),
    .addr_o           (addr_o),
    .wr_o             (wr_o),
    .memcnf_o         (memcnf_o),
    .data_write_o     (data_write_o),
    .data_available_i (data_available_i),
    .data_i           (data_i),
    .addr_needed      (addr_needed)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: bytes currently cached, keyed by byte address,
  // and which word address owns each line index.
  logic [7:0]  cached   [int unsigned];
  logic [31:0] resident [int];

  logic [31:0] obs_data;
  int          obs_lat;
  bit          obs_need;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_byp(input logic [31:0] a,
                                input logic [1:0] c);
    bit io, mis;
    io  = (a >= 32'h30000) && (a < 32'h30008);
    mis = (c == 2'b10 && a[0]) ||
          (c == 2'b11 && a[1:0] != 2'b00);
    return io || mis;
  endfunction

  function automatic int nbytes(input logic [1:0] c);
    return (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 4;
  endfunction

  task automatic model_clear();
    cached.delete();
    resident.delete();
  endtask

  task automatic model_evict(input int idx);
    if (resident.exists(idx)) begin
      for (int k = 0; k < 4; k++)
        cached.delete(resident[idx] + k);
      resident.delete(idx);
    end
  endtask

  task automatic access(input logic [31:0] a,
                        input bit          w,
                        input logic [1:0]  c,
                        input logic [31:0] wd,
                        input logic [31:0] fill,
                        input bit          flush_mid);
    bit          byp, hit, exp_mem, pulsed, done, flushed;
    int          n, idx, dly;
    logic [31:0] wa, expd, szm;
    byp  = is_byp(a, c);
    n    = nbytes(c);
    wa   = {a[31:2], 2'b00};
    idx  = int'(a[8:2]);
    hit  = !byp && !w;
    for (int i = 0; i < n; i++)
      if (!cached.exists(a + i)) hit = 1'b0;
    exp_mem = !hit;
    szm = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    expd = 32'h0;
    if (hit) begin
      for (int i = 0; i < n; i++)
        expd = expd | (32'(cached[a + i]) << (8 * i));
    end else if (!w && byp) begin
      expd = fill;
    end else if (!w) begin
      expd = (fill >> (8 * int'(a[1:0]))) & szm;
    end
    req_i = 1'b1; addr_i = a; wr_i = w;
    memcnf_i = c; data_write_i = wd;
    obs_need = 1'b0; pulsed = 1'b0; done = 1'b0;
    flushed = 1'b0; obs_lat = 0;
    dly = $urandom_range(0, 2);
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      data_available_i = 1'b0;
      addr_needed = 1'b0;
      flush_i = 1'b0;
      if (data_available_o) begin
        done = 1'b1;
        obs_lat = cyc;
        obs_data = data_o;
      end else if (data_needed && !pulsed) begin
        if (!obs_need) begin
          obs_need = 1'b1;
          chk("wr_o", 32'(wr_o), 32'(w));
          if (!byp && !w) begin
            chk("fill_addr", addr_o, wa);
            chk("fill_cnf", 32'(memcnf_o), 32'd3);
          end else begin
            chk("addr_o", addr_o, a);
            chk("memcnf_o", 32'(memcnf_o), 32'(c));
          end
          if (w) chk("wdata_o", data_write_o, wd);
          if (flush_mid) begin
            flush_i = 1'b1;
            flushed = 1'b1;
          end
        end
        if (dly == 0) begin
          pulsed = 1'b1;
          if (w) addr_needed = 1'b1;
          else begin
            data_available_i = 1'b1;
            data_i = fill;
          end
        end else begin
          dly--;
        end
      end
    end
    req_i = 1'b0;
    data_available_i = 1'b0;
    addr_needed = 1'b0;
    flush_i = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("mem_req", 32'(obs_need), 32'(exp_mem));
    if (hit) chk("hit_lat", obs_lat, 1);
    if (!w) chk("data_o", obs_data, expd);
    if (!byp) begin
      if (w) begin
        if (!(resident.exists(idx) && resident[idx] == wa))
          model_evict(idx);
        resident[idx] = wa;
        for (int i = 0; i < n; i++)
          cached[a + i] = 8'(wd >> (8 * i));
      end else if (!hit) begin
        model_evict(idx);
        resident[idx] = wa;
        for (int i = 0; i < 4; i++)
          cached[wa + i] = 8'(fill >> (8 * i));
      end
    end
    if (flushed) model_clear();
  endtask

  task automatic idle_flush();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    rst = 1'b1; req_i = 1'b0; addr_i = '0; wr_i = 1'b0;
    memcnf_i = 2'b00; data_write_i = '0; flush_i = 1'b0;
    data_available_i = 1'b0; data_i = '0; addr_needed = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {28'h0, data_needed, wr_o, data_available_o,
        |memcnf_o}, 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_data", data_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    access(32'h100, 0, 2'b11, 0, 32'hAABBCCDD, 0);
    chk("t1_miss", 32'(obs_need), 32'd1);
    chk("t1_data", obs_data, 32'hAABBCCDD);
    @(negedge clk);
    access(32'h100, 0, 2'b11, 0, 32'h0, 0);
    chk("t1_hit", 32'(obs_need), 32'd0);
    chk("t1_hdata", obs_data, 32'hAABBCCDD);
    @(negedge clk);
    access(32'h102, 0, 2'b01, 0, 32'h0, 0);
    chk("t2_byte", obs_data, 32'h000000BB);
    @(negedge clk);

    access(32'h201, 1, 2'b01, 32'h5A, 32'h0, 0);
    @(negedge clk);
    access(32'h201, 0, 2'b01, 0, 32'h0, 0);
    chk("t3_hit", 32'(obs_need), 32'd0);
    chk("t3_data", obs_data, 32'h5A);
    @(negedge clk);
    access(32'h200, 0, 2'b01, 0, 32'h11223344, 0);
    chk("t3_miss", 32'(obs_need), 32'd1);
    chk("t3_mdata", obs_data, 32'h44);
    @(negedge clk);

    access(32'h30004, 1, 2'b11, 32'hDEADBEEF, 32'h0, 0);
    @(negedge clk);
    access(32'h30000, 0, 2'b01, 0, 32'h12345678, 0);
    chk("t4_raw", obs_data, 32'h12345678);
    @(negedge clk);
    access(32'h30000, 0, 2'b01, 0, 32'h9, 0);
    chk("t4_again", 32'(obs_need), 32'd1);
    @(negedge clk);
    access(32'h30008, 0, 2'b01, 0, 32'h77, 0);
    @(negedge clk);
    access(32'h30008, 0, 2'b01, 0, 32'h0, 0);
    chk("t4_edge_hit", 32'(obs_need), 32'd0);
    @(negedge clk);

    idle_flush();
    access(32'h100, 0, 2'b11, 0, 32'hCAFEF00D, 1);
    chk("t5_fill", obs_data, 32'hCAFEF00D);
    @(negedge clk);
    access(32'h100, 0, 2'b11, 0, 32'h13579BDF, 0);
    chk("t5_remiss", 32'(obs_need), 32'd1);
    @(negedge clk);

    access(32'h103, 0, 2'b10, 0, 32'h0000BEEF, 0);
    chk("t6_misal", obs_data, 32'h0000BEEF);
    @(negedge clk);

    req_i = 1'b1; addr_i = 32'h100;
    wr_i = 1'b0; memcnf_i = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("cnf00", 32'(data_needed | data_available_o), 32'd0);
    end
    req_i = 1'b0;
    @(negedge clk);

    req_i = 1'b1; addr_i = 32'h104; wr_i = 1'b1;
    memcnf_i = 2'b11; data_write_i = 32'h01020304;
    @(negedge clk);
    chk("rst_pre", 32'(data_needed & wr_o), 32'd1);
    rst = 1'b1; req_i = 1'b0;
    @(negedge clk);
    chk("rstm_ctl", {28'h0, data_needed, wr_o, data_available_o,
        |memcnf_o}, 32'h0);
    chk("rstm_addr", addr_o, 32'h0);
    chk("rstm_wd", data_write_o, 32'h0);
    rst = 1'b0; addr_needed = 1'b1;
    @(negedge clk);
    addr_needed = 1'b0;
    chk("late_an", 32'(data_available_o | data_needed), 32'd0);
    @(negedge clk);
    chk("late_an2", 32'(data_available_o | data_needed), 32'd0);
    model_clear();
    access(32'h104, 0, 2'b11, 0, 32'h55AA55AA, 0);
    chk("rst_inval", 32'(obs_need), 32'd1);
    @(negedge clk);

    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 15) == 0) idle_flush();
      if ($urandom_range(0, 9) == 0)
        ra = 32'h2FFFC + 32'($urandom_range(0, 15));
      else
        ra = 32'h1000 + (32'($urandom_range(0, 3)) << 9) +
             32'($urandom_range(0, 63));
      access(ra, ($urandom_range(0, 2) == 0),
             2'($urandom_range(1, 3)), $urandom, $urandom,
             ($urandom_range(0, 19) == 0));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
Parametrised, direct-mapped, write-through data cache between the MEM stage and mem-control. Each line holds one 32-bit word with per-byte valid bits.
- Read misses fill the whole aligned word.
- Writes go through to memory and update or allocate the line.
- An I/O window and misaligned accesses bypass the cache.
- flush_i invalidates every line.

Parameters:
ADDR_WIDTH, 32, byte-address width.
INDEX_BITS, 7, log2 of line count (2^INDEX_BITS lines, one word each).
IO_BASE, 32'h30000, base of the uncached I/O window.
IO_SIZE_LOG2, 3, I/O window is 2^IO_SIZE_LOG2 bytes starting at IO_BASE.
CACHE_EN, 1, when 0 every access bypasses and no line is ever filled.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
req_i  in  1  MEM request valid; request fields are held stable until data_available_o.
addr_i  in  ADDR_WIDTH  byte address.
wr_i  in  1  1 = store, 0 = load.
memcnf_i  in  2  access size: 01 byte, 10 half, 11 word; 00 means no access.
data_write_i  in  32  store data, right-aligned.
flush_i  in  1  one-cycle pulse that invalidates all lines.
data_o  out  32  load data, right-aligned, upper bits zero.
data_available_o  out  1  one-cycle completion pulse, for loads and stores.
data_needed  out  1  memory request to mem-control; held high until the matching completion.
addr_o  out  ADDR_WIDTH  memory address.
wr_o  out  1  memory write enable.
memcnf_o  out  2  memory access size.
data_write_o  out  32  memory write data.
data_available_i  in  1  mem-control read data valid (one cycle).
data_i  in  32  mem-control read data.
addr_needed  in  1  mem-control write accepted (one cycle).

Behaviour:
- Address split: offset = addr[1:0]; index = addr[INDEX_BITS+1:2]; tag = addr[ADDR_WIDTH-1:INDEX_BITS+2].
- Reset: all outputs 0, state IDLE, all valid bits 0, flush_pending 0. Reset mid-operation abandons any outstanding memory request; a late data_available_i or addr_needed is ignored in IDLE.
- Acceptance: a request is accepted when state = IDLE, req_i = 1, memcnf_i != 00, and data_available_o = 0. Its fields are registered at acceptance. memcnf_i = 00 is never accepted.
- Bypass condition: addr in [IO_BASE, IO_BASE + 2^IO_SIZE_LOG2), or a misaligned access (half with offset[0] = 1, or word with offset != 0), or CACHE_EN = 0.
- State IDLE:
  - Flush: if flush_i or flush_pending is set, clear all valid bits this cycle and clear flush_pending. No request is accepted in that cycle.
  - Otherwise, on acceptance:
  - Load hit: tag matches and all addressed bytes are valid. Stay in IDLE; data_o and data_available_o are registered, so the response comes on the next cycle.
  - Load miss: go to RFILL.
  - Store: go to WTHRU.
  - Bypass access: go to BYP.
- State RFILL:
  - Outputs: data_needed = 1, wr_o = 0, memcnf_o = 11, addr_o = word-aligned address.
  - On data_available_i: write the whole word, set tag, set valid = 1111, drive data_o from data_i with the original size and offset, pulse data_available_o next cycle, return to IDLE.
- State WTHRU:
  - Outputs: data_needed = 1, wr_o = 1, with the original addr, memcnf and data.
  - On addr_needed: merge the written bytes into the line.
    - Tag hit: valid |= byte mask.
    - Tag miss: set tag and valid = byte mask.
  - Then pulse data_available_o and return to IDLE.
- State BYP:
  - Outputs: the original fields pass straight through; data_needed = 1.
  - Completion: loads complete on data_available_i with data_o = data_i; stores complete on addr_needed.
  - Cache state is not modified.
- Byte mask: byte = 0001 << offset; half = 0011 << offset; word = 1111.
- Load data extraction: data_o = (line >> 8*offset), truncated to the access size and zero-extended. Sign extension is done by MEM.
- flush_i outside IDLE sets flush_pending. The line update of a completing RFILL or WTHRU still happens, and the flush is applied in the next IDLE cycle, before any acceptance.
- Completion pulse while not waiting: data_available_i or addr_needed arriving while not waiting for it is ignored.
- data_needed is low in IDLE.

Decomposition:
Shared package dcache_pkg:
- memcnf encodings (MEMCNF_NONE/BYTE/HALF/WORD).
- state type (IDLE, RFILL, WTHRU, BYP).
- byte-mask function.
- load-extract function.

Sub-module dcache_line_store:
- Tag, data and 4-bit valid arrays.
- One combinational read port.
- One write port with byte mask and allocate flag.
- Synchronous clear-all.

Test Plan:
- Load miss then hit: reset; word load at 0x100 -> data_needed with addr_o 0x100, memcnf_o 11. Return data_i 0xAABBCCDD -> data_available_o one cycle later, data_o 0xAABBCCDD. Repeat the load -> data_available_o one cycle after acceptance, data_needed stays 0.
- Byte load after fill: after the fill above, byte load at 0x102 -> hit, data_o 0x000000BB.
- Write allocate and merge: byte store 0x5A at 0x201 on an empty line -> wr_o 1, memcnf_o 01, data_write_o 0x5A. After addr_needed, a byte load at 0x201 hits with 0x5A. A byte load at 0x200 misses, causing a word refill.
- I/O bypass: word store at 0x30004 -> pass-through, no line update. Byte load at 0x30000 -> memcnf_o 01 passed through; a following load at 0x30000 issues data_needed again, with no caching.
- Flush, including mid-refill: pulse flush_i while in RFILL for 0x100 -> refill completes. The next IDLE cycle clears the valid bits, so a load at 0x100 misses again.
- Misaligned access and reset mid-request: half load at 0x103 -> bypass with memcnf_o 10. Assert rst during WTHRU -> all outputs 0 next cycle, and a later addr_needed has no effect.
